// File: rtl/ctrl_pkg.sv
// Shared opcode values, state encoding and default sizes for the control sequencer.
package ctrl_pkg;

    localparam int unsigned OPW_DEF      = 3;
    localparam int unsigned WAIT_MAX_DEF = 15;

    localparam int unsigned OP_NOP   = 0;
    localparam int unsigned OP_LOAD  = 1;
    localparam int unsigned OP_STORE = 2;
    localparam int unsigned OP_ADD   = 3;
    localparam int unsigned OP_CLRA  = 4;
    localparam int unsigned OP_HALT  = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_M = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC_A  = 3'd4,
        S_EXEC_M  = 3'd5,
        S_WB      = 3'd6,
        S_HALT    = 3'd7
    } state_e;

endpackage

// File: rtl/mem_wait_cnt.sv
// Saturating count of cycles a memory access has waited for mem_rdy.
module mem_wait_cnt #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(WAIT_MAX);

    logic [CW-1:0] cnt_q;

    // Holds at CMAX instead of wrapping so expired stays asserted.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CMAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == CMAX);

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer driving the datapath register
// load and clear lines, with a memory-ready handshake and timeout to HALT.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW      = OPW_DEF,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_rdy,
    output logic           ld_pc,
    output logic           ld_mar,
    output logic           mar_sel,
    output logic           ld_ir,
    output logic           ld_mdr,
    output logic           ld_acc,
    output logic           alu_add,
    output logic           acc_clr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           busy,
    output logic           halted,
    output logic           err
);

    state_e         state_q;
    state_e         state_d;
    logic [OPW-1:0] op_q;
    logic           err_q;
    logic           in_mem;
    logic           expired;
    logic           timeout;
    logic           dec_exec;
    logic           op_q_store;

    assign in_mem     = (state_q == S_FETCH_M) || (state_q == S_EXEC_M);
    assign timeout    = in_mem && !mem_rdy && expired;
    assign dec_exec   = (opcode == OPW'(OP_LOAD)) || (opcode == OPW'(OP_STORE))
                      || (opcode == OPW'(OP_ADD));
    assign op_q_store = (op_q == OPW'(OP_STORE));

    // Counter restarts from zero whenever a memory state is entered.
    mem_wait_cnt #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk     (clk),
        .clr     (clr),
        .clear   (!in_mem),
        .enable  (in_mem && !mem_rdy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

    // Next state and Mealy control outputs.
    always_comb begin
        state_d = state_q;
        ld_pc   = 1'b0;
        ld_mar  = 1'b0;
        mar_sel = 1'b0;
        ld_ir   = 1'b0;
        ld_mdr  = 1'b0;
        ld_acc  = 1'b0;
        alu_add = 1'b0;
        acc_clr = 1'b1;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        busy    = (state_q != S_IDLE) && (state_q != S_HALT);
        halted  = (state_q == S_HALT);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH_A;
                end
            end
            S_FETCH_A: begin
                ld_mar  = 1'b1;
                state_d = S_FETCH_M;
            end
            S_FETCH_M: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    ld_ir   = 1'b1;
                    ld_pc   = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_exec) begin
                    state_d = S_EXEC_A;
                end else if (opcode == OPW'(OP_HALT)) begin
                    state_d = S_HALT;
                end else begin
                    acc_clr = (opcode != OPW'(OP_CLRA));
                    state_d = S_FETCH_A;
                end
            end
            S_EXEC_A: begin
                ld_mar  = 1'b1;
                mar_sel = 1'b1;
                state_d = S_EXEC_M;
            end
            S_EXEC_M: begin
                mem_wr = op_q_store;
                mem_rd = !op_q_store;
                if (mem_rdy) begin
                    ld_mdr  = !op_q_store;
                    state_d = op_q_store ? S_FETCH_A : S_WB;
                end else if (expired) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                ld_acc  = 1'b1;
                alu_add = (op_q == OPW'(OP_ADD));
                state_d = S_FETCH_A;
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH_A;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: an instruction-level model expands each instruction into
// its expected per-cycle control vector; every cycle is compared against the DUT.
module tb_ctrl_seq;
    import ctrl_pkg::*;

    localparam int unsigned OPW      = 3;
    localparam int unsigned WAIT_MAX = 15;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic [OPW-1:0] opcode;
    logic           mem_rdy;
    logic ld_pc, ld_mar, mar_sel, ld_ir, ld_mdr, ld_acc, alu_add, acc_clr;
    logic mem_rd, mem_wr, busy, halted, err;

    ctrl_seq #(.OPW(OPW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .opcode  (opcode),
        .mem_rdy (mem_rdy),
        .ld_pc   (ld_pc),
        .ld_mar  (ld_mar),
        .mar_sel (mar_sel),
        .ld_ir   (ld_ir),
        .ld_mdr  (ld_mdr),
        .ld_acc  (ld_acc),
        .alu_add (alu_add),
        .acc_clr (acc_clr),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .busy    (busy),
        .halted  (halted),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ld_pc, ld_mar, mar_sel, ld_ir, ld_mdr, ld_acc, alu_add, acc_clr;
        logic mem_rd, mem_wr, busy, halted, err;
    } outv_t;

    typedef struct packed {
        logic           start;
        logic [OPW-1:0] op;
        logic           rdy;
    } stim_t;

    stim_t stim_q[$];
    outv_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    logic  m_err       = 1'b0;
    logic  m_halted    = 1'b0;
    logic  noise       = 1'b0;
    int    n_busy, n_irpc, n_mdr, n_rd, n_wr, n_acc, n_clrlow, n_halted;

    function automatic outv_t dut_vec();
        outv_t v;
        v = '{ld_pc, ld_mar, mar_sel, ld_ir, ld_mdr, ld_acc, alu_add, acc_clr,
              mem_rd, mem_wr, busy, halted, err};
        return v;
    endfunction

    function automatic outv_t idle_out();
        outv_t v;
        v = '0;
        v.acc_clr = 1'b1;
        v.halted  = m_halted;
        v.err     = m_err;
        return v;
    endfunction

    function automatic outv_t busy_out();
        outv_t v;
        v = '0;
        v.acc_clr = 1'b1;
        v.busy    = 1'b1;
        v.err     = m_err;
        return v;
    endfunction

    function automatic logic tog();
        noise = ~noise;
        return noise;
    endfunction

    task automatic check_vec(input string name, input outv_t want);
        outv_t got;
        got = dut_vec();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s vec %0d @%0t: got %b want %b (pc mar sel ir mdr acc add clr rd wr busy halt err)",
                     name, vectors, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input logic st, input logic [OPW-1:0] op, input logic rdy, input outv_t e);
        stim_t s;
        s.start = st;
        s.op    = op;
        s.rdy   = rdy;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Cycles sitting in IDLE or HALT without start.
    task automatic gen_wait(input int n);
        for (int i = 0; i < n; i++) push(1'b0, OPW'($urandom), tog(), idle_out());
    endtask

    task automatic gen_start();
        push(1'b1, OPW'($urandom), tog(), idle_out());
        m_halted = 1'b0;
    endtask

    // One memory access: waits beyond WAIT_MAX end in a timeout to HALT.
    task automatic gen_mem(input logic is_fetch, input logic wr, input logic [OPW-1:0] garb,
                           input int waits, output logic faulted);
        outv_t e;
        int    nw;
        faulted = 1'b0;
        nw = (waits > int'(WAIT_MAX)) ? int'(WAIT_MAX) + 1 : waits;
        for (int i = 0; i < nw; i++) begin
            e = busy_out();
            e.mem_rd = !wr;
            e.mem_wr = wr;
            push(tog(), garb, 1'b0, e);
        end
        if (waits > int'(WAIT_MAX)) begin
            m_err    = 1'b1;
            m_halted = 1'b1;
            faulted  = 1'b1;
        end else begin
            e = busy_out();
            e.mem_rd = !wr;
            e.mem_wr = wr;
            if (is_fetch) begin
                e.ld_ir = 1'b1;
                e.ld_pc = 1'b1;
            end else begin
                e.ld_mdr = !wr;
            end
            push(tog(), garb, 1'b1, e);
        end
    endtask

    // Opcode is only presented correctly in DECODE; other cycles carry its complement.
    task automatic gen_instr(input int unsigned op, input int fw, input int ew, input bit partial);
        outv_t          e;
        logic           f;
        logic           n;
        logic           is_st;
        logic [OPW-1:0] o;
        logic [OPW-1:0] garb;
        o     = OPW'(op);
        garb  = ~o;
        is_st = (op == OP_STORE);
        e = busy_out();
        e.ld_mar = 1'b1;
        n = tog();
        push(n, garb, ~n, e);
        gen_mem(1'b1, 1'b0, garb, fw, f);
        if (f) return;
        e = busy_out();
        if (op == OP_CLRA) e.acc_clr = 1'b0;
        n = tog();
        push(n, o, ~n, e);
        if (op == OP_HALT) begin
            m_halted = 1'b1;
            return;
        end
        if (!(op == OP_LOAD || op == OP_STORE || op == OP_ADD)) return;
        e = busy_out();
        e.ld_mar  = 1'b1;
        e.mar_sel = 1'b1;
        n = tog();
        push(n, garb, ~n, e);
        if (partial) begin
            e = busy_out();
            e.mem_rd = !is_st;
            e.mem_wr = is_st;
            push(tog(), garb, 1'b0, e);
            return;
        end
        gen_mem(1'b0, is_st, garb, ew, f);
        if (f || is_st) return;
        e = busy_out();
        e.ld_acc  = 1'b1;
        e.alu_add = (op == OP_ADD);
        n = tog();
        push(n, garb, ~n, e);
    endtask

    task automatic reset_stats();
        n_busy = 0; n_irpc = 0; n_mdr = 0; n_rd = 0;
        n_wr = 0; n_acc = 0; n_clrlow = 0; n_halted = 0;
    endtask

    // Apply each queued stimulus after a rising edge, compare at the falling edge.
    task automatic run_queue(input string name);
        stim_t s;
        outv_t e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            start   = s.start;
            opcode  = s.op;
            mem_rdy = s.rdy;
            @(negedge clk);
            check_vec(name, e);
            n_busy   += int'(busy);
            n_irpc   += int'(ld_ir & ld_pc);
            n_mdr    += int'(ld_mdr);
            n_rd     += int'(mem_rd);
            n_wr     += int'(mem_wr);
            n_acc    += int'(ld_acc);
            n_clrlow += int'(!acc_clr);
            n_halted += int'(halted);
        end
    endtask

    initial begin
        outv_t rst_v;
        clr = 1'b0; start = 1'b0; opcode = '0; mem_rdy = 1'b0;
        rst_v = '0;
        rst_v.acc_clr = 1'b1;
        #12;
        check_vec("reset_outputs", rst_v);
        #10 clr = 1'b1;

        reset_stats();
        gen_wait(2); gen_start(); gen_instr(OP_NOP, 0, 0, 1'b0);
        run_queue("nop");
        check_int("nop_busy_cycles", n_busy, 3);
        check_int("nop_ir_pc_pulse", n_irpc, 1);

        reset_stats();
        gen_instr(OP_LOAD, 0, 3, 1'b0);
        run_queue("load_wait3");
        check_int("load_wait3_cycles", n_busy, 9);
        check_int("load_wait3_mem_rd", n_rd, 5);
        check_int("load_wait3_ld_mdr", n_mdr, 1);

        reset_stats();
        gen_instr(OP_ADD, 0, 0, 1'b0); gen_instr(OP_STORE, 0, 0, 1'b0);
        run_queue("add_store");
        check_int("add_store_cycles", n_busy, 11);
        check_int("add_store_mem_wr", n_wr, 1);
        check_int("add_store_ld_acc", n_acc, 1);

        reset_stats();
        gen_instr(OP_CLRA, 0, 0, 1'b0); gen_instr(OP_HALT, 0, 0, 1'b0);
        gen_wait(2); gen_start();
        run_queue("clra_halt");
        check_int("clra_acc_clr_low", n_clrlow, 1);
        check_int("clra_halt_cycles", n_busy, 6);
        check_int("halt_cycles", n_halted, 3);

        reset_stats();
        gen_instr(5, 2, 0, 1'b0); gen_instr(6, 1, 0, 1'b0);
        run_queue("op5_op6");
        check_int("op5_op6_err", int'(err), 0);

        reset_stats();
        gen_instr(OP_LOAD, int'(WAIT_MAX), int'(WAIT_MAX), 1'b0);
        run_queue("load_edge_wait");
        check_int("edge_wait_cycles", n_busy, 36);
        check_int("edge_wait_err", int'(err), 0);

        reset_stats();
        gen_instr(OP_NOP, int'(WAIT_MAX) + 1, 0, 1'b0);
        run_queue("fetch_timeout");
        check_int("fetch_timeout_cycles", n_busy, 17);

        gen_start(); gen_instr(OP_LOAD, 0, int'(WAIT_MAX) + 1, 1'b0);
        gen_start(); gen_instr(OP_STORE, 0, 0, 1'b1);
        run_queue("exec_timeout_then_store");
        check_int("store_mid_mem_wr", int'(mem_wr), 1);
        check_int("store_mid_err", int'(err), 1);

        #2 clr = 1'b0;
        #1;
        check_vec("async_clear", rst_v);
        @(posedge clk);
        @(negedge clk);
        check_vec("held_clear", rst_v);
        #2 clr = 1'b1;
        m_err = 1'b0; m_halted = 1'b0;

        gen_wait(1); gen_start(); gen_instr(OP_ADD, 1, 0, 1'b0);
        run_queue("after_clear");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle control sequencer for the processor datapath.
- Drives the load (c) and synchronous active-low clear lines of the datapath's load/store registers: PC, MAR, IR, MDR, ACC.
- Steps fetch/decode/execute per instruction, handshakes with memory via mem_rdy, and halts on the HALT opcode or a memory timeout.

Parameters:
- OPW, 3, opcode width in bits.
- WAIT_MAX, 15, maximum cycles a memory state waits for mem_rdy before faulting.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  begin or resume execution; sampled in IDLE and HALT only.
- opcode  in  OPW  IR opcode field; valid in DECODE.
- mem_rdy  in  1  memory done; completes the current access this cycle.
- ld_pc  out  1  PC load/increment enable.
- ld_mar  out  1  MAR load.
- mar_sel  out  1  MAR source: 0 = PC, 1 = IR address field.
- ld_ir  out  1  IR load.
- ld_mdr  out  1  MDR load.
- ld_acc  out  1  ACC load.
- alu_add  out  1  ACC source: 1 = ACC+MDR, 0 = MDR.
- acc_clr  out  1  ACC synchronous active-low clear line.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- busy  out  1  high in any state other than IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, wait counter=0, err=0.
  - All ld_*, mem_*, mar_sel, alu_add = 0; acc_clr = 1.
  - Reset mid-access aborts the access immediately; outputs drop in the same cycle.
- Outputs: combinational decode of the registered state, plus mem_rdy/opcode where noted (Mealy).
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 CLRA, 7 HALT. 5 and 6 execute as NOP and do not set err.
- States and transitions:
  - IDLE: start=1 -> FETCH_A.
  - FETCH_A: ld_mar=1, mar_sel=0 -> FETCH_M.
  - FETCH_M: mem_rd=1.
    - If mem_rdy: ld_ir=1 and ld_pc=1 in the same cycle -> DECODE.
    - Else stay.
  - DECODE (on opcode):
    - LOAD/STORE/ADD -> EXEC_A.
    - CLRA: acc_clr=0 this cycle -> FETCH_A.
    - NOP/5/6 -> FETCH_A.
    - HALT -> HALT.
  - EXEC_A: ld_mar=1, mar_sel=1 -> EXEC_M.
  - EXEC_M:
    - STORE: mem_wr=1; on mem_rdy -> FETCH_A.
    - LOAD/ADD: mem_rd=1; on mem_rdy ld_mdr=1 -> WB.
    - Else stay.
    - Opcode is latched into an internal register in DECODE; EXEC_M and WB use the latched copy.
  - WB: ld_acc=1, alu_add=1 iff ADD -> FETCH_A.
  - HALT: halted=1; start=1 -> FETCH_A. PC is not cleared; err is kept.
- Latency with mem_rdy held high:
  - NOP/CLRA/HALT: 3 cycles.
  - STORE: 5 cycles.
  - LOAD/ADD: 6 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH_M/EXEC_M; increments each cycle in those states with mem_rdy=0.
  - When it equals WAIT_MAX with mem_rdy=0: err<=1 and next state HALT. mem_*, ld_* are not asserted that cycle beyond mem_rd/mem_wr.
  - mem_rdy=1 on the same cycle the counter reaches WAIT_MAX: the access completes normally.
  - Counter width is clog2(WAIT_MAX+1) and saturates, no wrap.
- start in any state other than IDLE/HALT is ignored.
- mem_rd and mem_wr are never high together. At most one of ld_mar/ld_ir/ld_mdr/ld_acc is high per cycle, except ld_ir+ld_pc.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams (OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_CLRA, OP_HALT);
  - state encodings (S_IDLE ... S_HALT, 3 bits);
  - OPW default.
- Sub-module mem_wait_cnt: saturating wait counter with inputs clear, enable, and parameter WAIT_MAX; output expired.

Test Plan:
- Reset then start=1, opcode=0, mem_rdy=1: states IDLE->FETCH_A->FETCH_M->DECODE->FETCH_A. ld_ir and ld_pc are high together for exactly 1 cycle.
- opcode=1 (LOAD), mem_rdy low 3 cycles in EXEC_M: mem_rd held 4 cycles, ld_mdr pulses on the rdy cycle, ld_acc=1 with alu_add=0 next cycle. Instruction takes 9 cycles.
- opcode=3 (ADD) then opcode=2 (STORE): WB has ld_acc=1, alu_add=1. STORE asserts mem_wr only, no ld_acc, and returns to FETCH_A after 5 cycles.
- opcode=4 then opcode=7: acc_clr=0 for exactly 1 DECODE cycle. Then halted=1, busy=0; start=1 returns to FETCH_A.
- WAIT_MAX=15, mem_rdy held 0 in FETCH_M: after 15 wait cycles the block enters HALT with err=1. A second run with mem_rdy rising exactly on the 15th cycle completes normally with err=0.
- clr asserted mid EXEC_M with mem_wr=1: mem_wr and busy fall without a clock edge, state=IDLE, err=0.
